spi_master_seq: RTL and testbench

- Master-side transaction sequencer for the SPI byte datapath; drives the bus for the mode-0..3 receive/shift logic.
- Accepts one byte request per handshake, generates ss_n/sclk/mosi per CPOL/CPHA and LSBFE, and samples miso into an 8-bit receive word.
- Returns the received byte with a one-cycle valid pulse.
- Sits between the register/CPU side (start/ready) and the SPI pins.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_baud_tick.sv | 28 ++
 rtl/spi_master_seq.sv | 141 ++++++++++++++
 tb/tb_spi_master_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master sequencer.
// Holds the FSM encoding, mode constants and the wire bit-order helper.
package spi_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SETUP    = 2'b01,
    TRANSFER = 2'b10,
    STOP     = 2'b11
  } state_e;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Byte position of the idx-th bit on the wire for the selected bit order.
  function automatic logic [2:0] wire_pos(input logic [2:0] idx, input logic lsbfe);
    return lsbfe ? idx : 3'd7 - idx;
  endfunction

endpackage

// File: rtl/spi_baud_tick.sv
// Half-period tick generator: counts 0..div and pulses tick on count == div.
// A clear restarts the count so the first half-period is always full length.
module spi_baud_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == div);

  // NOTE: flops are written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_seq.sv
// SPI master byte sequencer: one byte per start/ready handshake, modes 0..3,
// MSB- or LSB-first, programmable half-period; returns the received byte.
module spi_master_seq
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              miso,
  output logic              ready,
  output logic              ss_n,
  output logic              sclk,
  output logic              mosi,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid
);

  state_e state, next_state;

  logic [BYTE_W-1:0] tx_q;
  logic [BYTE_W-1:0] rx_shift;
  logic [BYTE_W-1:0] rx_shift_nxt;
  logic              cpha_q;
  logic              lsbfe_q;
  logic [DIV_W-1:0]  baud_q;
  logic [3:0]        edge_cnt;
  logic              sclk_q;
  logic              mosi_q;

  logic              tick;
  logic              accept;
  logic              last_edge;
  logic              sample_en;
  logic              drive_en;
  logic [2:0]        bit_idx;
  logic [2:0]        drive_idx;

  spi_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .div   (baud_q),
    .tick  (tick)
  );

  assign sclk = sclk_q;
  assign mosi = mosi_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal gets a default first so no path leaves one unassigned.
  always_comb begin
    next_state   = state;
    ready        = 1'b0;
    ss_n         = 1'b0;
    accept       = 1'b0;
    sample_en    = 1'b0;
    drive_en     = 1'b0;
    rx_shift_nxt = rx_shift;
    bit_idx      = edge_cnt[3:1];
    last_edge    = (edge_cnt == 4'd15);
    // cpha=0 shifts bit j on edge 2j, i.e. one bit ahead of the current pair.
    drive_idx    = cpha_q ? bit_idx : bit_idx + 3'd1;

    case (state)
      IDLE: begin
        ready  = 1'b1;
        ss_n   = 1'b1;
        accept = start;
        if (start) next_state = SETUP;
      end
      SETUP: begin
        if (tick) next_state = TRANSFER;
      end
      TRANSFER: begin
        if (tick) begin
          // An even edge_cnt is an odd edge number, i.e. a leading edge.
          sample_en = (edge_cnt[0] == cpha_q);
          drive_en  = (edge_cnt[0] != cpha_q) && !last_edge;
          if (last_edge) next_state = STOP;
        end
      end
      STOP: begin
        if (tick) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (sample_en) rx_shift_nxt[wire_pos(bit_idx, lsbfe_q)] = miso;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q     <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      cpha_q   <= 1'b0;
      lsbfe_q  <= 1'b0;
      baud_q   <= '0;
      edge_cnt <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (accept) begin
        tx_q     <= tx_data;
        cpha_q   <= cpha;
        lsbfe_q  <= lsbfe;
        baud_q   <= baud_div;
        edge_cnt <= '0;
        sclk_q   <= cpol;
        if (!cpha) mosi_q <= lsbfe ? tx_data[0] : tx_data[BYTE_W-1];
      end else if (state == TRANSFER && tick) begin
        sclk_q   <= ~sclk_q;
        edge_cnt <= edge_cnt + 4'd1;
        rx_shift <= rx_shift_nxt;
        if (drive_en) mosi_q <= tx_q[wire_pos(drive_idx, lsbfe_q)];
        // The final sample lands on edge 16 for cpha=1, so publish the merged value.
        if (last_edge) begin
          rx_data  <= rx_shift_nxt;
          rx_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_seq.sv
// Scoreboard bench for spi_master_seq: a behavioural SPI slave plus queued
// expectations for received bytes, wire bytes and handshake latency.
module tb_spi_master_seq;
  import spi_pkg::*;

  localparam int DIV_W = 8;
  localparam int WAIT_LIMIT = 20000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       tx_data;
  logic             cpol, cpha, lsbfe;
  logic [DIV_W-1:0] baud_div;
  logic             miso;
  logic             ready, ss_n, sclk, mosi;
  logic [7:0]       rx_data;
  logic             rx_valid;

  spi_master_seq #(.DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .tx_data  (tx_data),
    .cpol     (cpol),
    .cpha     (cpha),
    .lsbfe    (lsbfe),
    .baud_div (baud_div),
    .miso     (miso),
    .ready    (ready),
    .ss_n     (ss_n),
    .sclk     (sclk),
    .mosi     (mosi),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Current transaction as seen by the slave model.
  logic       cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsbfe = 1'b0, loopback = 1'b1;
  logic [7:0] cur_slv = 8'h00;
  int         cur_div = 0;

  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_mosi_q[$];
  int         acc_q[$];

  function automatic int bit_pos(input int j, input logic lsb);
    return lsb ? j : 7 - j;
  endfunction

  // Behavioural slave
  logic slv_miso = 1'b0;
  assign miso = loopback ? mosi : slv_miso;

  logic       prev_sclk, prev_ss_n = 1'b1, leading;
  int         slv_edges = 0, slv_in = 0, slv_out = 0, last_evt = 0;
  logic [7:0] slv_rx = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      slv_edges = 0;
      slv_in    = 0;
      slv_out   = 0;
    end else if (ss_n === 1'b1) begin
      if (prev_ss_n === 1'b0 && exp_mosi_q.size() > 0) begin
        check("stop_half_period", cyc - last_evt, cur_div + 1);
        check("sclk_toggles", slv_edges, 16);
        check("mosi_byte", 32'(slv_rx), 32'(exp_mosi_q.pop_front()));
      end
      slv_edges = 0;
      slv_in    = 0;
      slv_out   = cur_cpha ? 0 : 1;
      slv_miso  = cur_slv[bit_pos(0, cur_lsbfe)];
    end else if (ss_n === 1'b0) begin
      if (prev_ss_n === 1'b1) begin
        last_evt = cyc;
      end else if (sclk !== prev_sclk) begin
        check("half_period", cyc - last_evt, (slv_edges == 0 ? 2 : 1) * (cur_div + 1));
        last_evt = cyc;
        slv_edges++;
        leading = (sclk !== cur_cpol);
        if (leading != cur_cpha) begin
          if (slv_in < 8) slv_rx[bit_pos(slv_in, cur_lsbfe)] = mosi;
          slv_in++;
        end else begin
          if (slv_out < 8) slv_miso = cur_slv[bit_pos(slv_out, cur_lsbfe)];
          slv_out++;
        end
      end
    end
    prev_sclk = sclk;
    prev_ss_n = ss_n;
  end

  // Received-byte monitor
  always @(negedge clk) begin
    if (!rst && rx_valid === 1'b1) begin
      if (exp_rx_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rx_valid_unexpected: actual rx_valid=1 rx_data=%0h required no pulse (cycle %0d)",
                 rx_data, cyc);
      end else begin
        check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
      end
    end
  end

  // Handshake latency monitor: ready must return 1 + 18*(baud_div+1) cycles after accept.
  logic prev_ready = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      prev_ready = 1'b1;
    end else begin
      if (start === 1'b1 && ready === 1'b1) acc_q.push_back(cyc + 1 + 18 * (int'(baud_div) + 1));
      if (ready === 1'b1 && prev_ready === 1'b0 && acc_q.size() > 0)
        check("ready_latency", cyc, acc_q.pop_front());
      prev_ready = ready;
    end
  end

  task automatic wait_ready(input string what);
    int n = 0;
    while (ready !== 1'b1 && n < WAIT_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: actual ready=%b required 1 within %0d cycles", what, ready, WAIT_LIMIT);
    end
  endtask

  task automatic send(input logic [7:0] tx, input logic [1:0] mode, input logic lsb,
                      input logic [7:0] div, input logic [7:0] slv, input logic lb);
    wait_ready("send");
    @(posedge clk); #1;
    {cur_cpol, cur_cpha} = mode;
    cur_lsbfe = lsb;
    cur_div   = int'(div);
    cur_slv   = slv;
    loopback  = lb;
    exp_rx_q.push_back(lb ? tx : slv);
    exp_mosi_q.push_back(tx);
    tx_data     = tx;
    {cpol, cpha} = mode;
    lsbfe       = lsb;
    baud_div    = div;
    start       = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    tx_data  = 8'($urandom);
    cpol     = 1'($urandom);
    cpha     = 1'($urandom);
    lsbfe    = 1'($urandom);
    baud_div = 8'($urandom);
  endtask

  initial begin
    int n;
    logic [7:0] t, s;
    rst = 1'b1; start = 1'b0; tx_data = 8'h00;
    cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; baud_div = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 1);
    check("reset_ss_n", 32'(ss_n), 1);
    check("reset_sclk", 32'(sclk), 0);
    check("reset_mosi", 32'(mosi), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_rx_valid", 32'(rx_valid), 0);
    rst = 1'b0;

    // Abort at edge 7 (mode 3 so idle-high sclk must drop to the reset level).
    send(8'h5A, MODE3, 1'b0, 8'd1, 8'h00, 1'b1);
    n = 0;
    while (slv_edges < 7 && n < WAIT_LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_edge_reached", slv_edges, 7);
    rst = 1'b1;
    exp_rx_q.delete();
    exp_mosi_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    check("abort_ss_n", 32'(ss_n), 1);
    check("abort_sclk", 32'(sclk), 0);
    check("abort_ready", 32'(ready), 1);
    check("abort_rx_valid", 32'(rx_valid), 0);
    check("abort_rx_data", 32'(rx_data), 0);
    rst = 1'b0;

    // Directed cases
    send(8'hA5, MODE0, 1'b0, 8'd1, 8'h00, 1'b1);
    send(8'h3C, MODE3, 1'b1, 8'd0, 8'h00, 1'b1);
    wait_ready("mode3");
    check("mode3_idle_sclk", 32'(sclk), 1);
    send(8'h96, MODE1, 1'b0, 8'd1, 8'hC3, 1'b0);

    // A start during TRANSFER must be ignored.
    send(8'h81, MODE0, 1'b0, 8'd3, 8'h00, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    tx_data = 8'hFF;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    // Randomized transfers
    for (int i = 0; i < 20; i++) begin
      t = 8'($urandom);
      s = 8'($urandom);
      send(t, 2'($urandom), 1'($urandom), 8'($urandom_range(0, 3)), s, 1'($urandom));
    end

    // Back-to-back with start held high and the slowest divider.
    wait_ready("b2b_first");
    @(posedge clk); #1;
    cur_cpol = 1'b0; cur_cpha = 1'b0; cur_lsbfe = 1'b0; cur_div = 255; loopback = 1'b1;
    {cpol, cpha} = MODE0;
    lsbfe    = 1'b0;
    baud_div = 8'hFF;
    tx_data  = 8'h12;
    exp_rx_q.push_back(8'h12);
    exp_mosi_q.push_back(8'h12);
    start = 1'b1;
    @(posedge clk); #1;
    tx_data = 8'h34;
    exp_rx_q.push_back(8'h34);
    exp_mosi_q.push_back(8'h34);
    wait_ready("b2b_second");
    @(posedge clk); #1;
    check("b2b_accept_next_cycle", 32'(ready), 0);
    start = 1'b0;

    wait_ready("final");
    repeat (3) @(posedge clk);
    #1;
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("mosi_queue_drained", exp_mosi_q.size(), 0);
    check("accept_queue_drained", acc_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
